// File: rtl/minn_detect_controller.sv
// Minn preamble detection controller: threshold test, peak tracking, single report per preamble.
// Optional detection counter enabled by defining MINN_CTRL_DET_COUNT_EN.
module minn_detect_controller #(
  parameter int unsigned W_R       = 34,
  parameter int unsigned W_E       = 34,
  parameter int unsigned W_TH      = 8,
  parameter int unsigned W_IDX     = 32,
  parameter int unsigned GAP       = 16,
  parameter int unsigned MAX_TRACK = 1024,
  parameter int unsigned HOLDOFF   = 2048
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [W_TH-1:0]         thresh,
  output logic                    dp_rst,
  input  logic                    in_valid,
  input  logic signed [W_R-1:0]   r_current,
  input  logic signed [W_R-1:0]   r_delayed,
  input  logic signed [W_E-1:0]   e_current,
  input  logic signed [W_E-1:0]   e_delayed_1q,
  input  logic signed [W_E-1:0]   e_delayed_2q,
  output logic                    busy,
  output logic                    det_valid,
  output logic [W_IDX-1:0]        det_index,
  output logic signed [W_R:0]     det_peak,
  output logic [15:0]             det_count
);

  localparam int unsigned W_C  = W_R + 1;
  localparam int unsigned W_EN = W_E + 1;
  localparam int unsigned PW   = ((W_R > W_E) ? W_R : W_E) + W_TH + 2;
  localparam int unsigned GW   = $clog2(GAP + 1);
  localparam int unsigned TW   = $clog2(MAX_TRACK + 1);
  localparam int unsigned HW   = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {IDLE, ARM, SEARCH, TRACK, REPORT, HOLDOFF_ST} state_t;

  state_t state, state_d;

  logic                   run;
  logic [W_TH-1:0]        thr_q;
  logic [W_IDX-1:0]       idx_cnt;

  logic                   s1_valid;
  logic signed [W_C-1:0]  s1_corr;
  logic signed [W_EN-1:0] s1_energy;
  logic [W_IDX-1:0]       s1_idx;

  logic                   s2_valid;
  logic                   s2_hit;
  logic signed [W_C-1:0]  s2_corr;
  logic [W_IDX-1:0]       s2_idx;

  logic signed [PW-1:0]   lhs, rhs, thr_ext;
  logic                   hit;

  logic signed [W_C-1:0]  peak, peak_d;
  logic [W_IDX-1:0]       peak_idx, peak_idx_d;
  logic [GW-1:0]          gap_cnt, gap_d;
  logic [TW-1:0]          trk_cnt, trk_d;
  logic [HW-1:0]          ho_cnt, ho_d;

  logic                   unused_e2q;
  assign unused_e2q = ^e_delayed_2q;

  // Pipeline and index only advance while detection is running.
  assign run = (state != IDLE) && enable;

  // Stage 1: form correlation and energy terms with the beat index.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_corr   <= '0;
      s1_energy <= '0;
      s1_idx    <= '0;
      idx_cnt   <= '0;
    end else if (!run) begin
      s1_valid <= 1'b0;
      idx_cnt  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_corr   <= W_C'(r_current) + W_C'(r_delayed);
        s1_energy <= W_EN'(e_current) + W_EN'(e_delayed_1q);
        s1_idx    <= idx_cnt;
        idx_cnt   <= idx_cnt + W_IDX'(1);
      end
    end
  end

  // Full-width threshold test: corr * 2^W_TH >= thr * energy, corr strictly positive.
  assign thr_ext = PW'(thr_q);
  assign lhs     = PW'(s1_corr) <<< W_TH;
  assign rhs     = PW'(s1_energy) * thr_ext;
  assign hit     = !s1_corr[W_C-1] && (s1_corr != '0) && (lhs >= rhs);

  // Stage 2: registered hit decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_corr  <= '0;
      s2_idx   <= '0;
    end else if (!run) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hit  <= hit;
        s2_corr <= s1_corr;
        s2_idx  <= s1_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    peak_d     = peak;
    peak_idx_d = peak_idx;
    gap_d      = gap_cnt;
    trk_d      = trk_cnt;
    ho_d       = ho_cnt;
    case (state)
      IDLE: if (enable) state_d = ARM;
      ARM:  if (s2_valid) state_d = SEARCH;
      SEARCH: begin
        if (s2_valid && s2_hit) begin
          state_d    = TRACK;
          peak_d     = s2_corr;
          peak_idx_d = s2_idx;
          gap_d      = '0;
          trk_d      = TW'(1);
        end
      end
      TRACK: begin
        if (s2_valid) begin
          // Strict compare keeps the earliest beat on ties.
          if (s2_hit && (s2_corr > peak)) begin
            peak_d     = s2_corr;
            peak_idx_d = s2_idx;
          end
          gap_d = s2_hit ? '0 : gap_cnt + GW'(1);
          trk_d = trk_cnt + TW'(1);
          if ((gap_d == GW'(GAP)) || (trk_d == TW'(MAX_TRACK))) state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = HOLDOFF_ST;
        ho_d    = '0;
      end
      HOLDOFF_ST: begin
        if (s2_valid) begin
          ho_d = ho_cnt + HW'(1);
          if (ho_d == HW'(HOLDOFF)) state_d = SEARCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Tracking registers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q     <= '0;
      peak      <= '0;
      peak_idx  <= '0;
      gap_cnt   <= '0;
      trk_cnt   <= '0;
      ho_cnt    <= '0;
      dp_rst    <= 1'b1;
      busy      <= 1'b0;
      det_valid <= 1'b0;
      det_index <= '0;
      det_peak  <= '0;
    end else begin
      if ((state == IDLE) && enable) thr_q <= thresh;
      if (state_d == IDLE) begin
        gap_cnt <= '0;
        trk_cnt <= '0;
        ho_cnt  <= '0;
      end else begin
        gap_cnt <= gap_d;
        trk_cnt <= trk_d;
        ho_cnt  <= ho_d;
      end
      peak      <= peak_d;
      peak_idx  <= peak_idx_d;
      dp_rst    <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      det_valid <= (state_d == REPORT);
      if (state_d == REPORT) begin
        det_index <= peak_idx_d;
        det_peak  <= peak_d;
      end
    end
  end

`ifdef MINN_CTRL_DET_COUNT_EN
  // Saturating report counter, updated alongside det_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_count <= '0;
    end else if ((state_d == REPORT) && (det_count != 16'hFFFF)) begin
      det_count <= det_count + 16'd1;
    end
  end
`else
  assign det_count = '0;
`endif

endmodule
